// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS memory-access stage.
// Load-mode encodings, FSM states, MEM/WB bundle and lane helpers.
package mips_mem_pkg;

   localparam logic [1:0] LM_WORD   = 2'b00;
   localparam logic [1:0] LM_HALF_S = 2'b01;
   localparam logic [1:0] LM_BYTE_S = 2'b10;
   localparam logic [1:0] LM_BYTE_U = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } mem_state_t;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_to_reg;
      logic        misalign;
      logic [4:0]  dest;
      logic [31:0] alu;
      logic [31:0] rdata;
   } mem_wb_t;

   function automatic logic [3:0] byte_en(
      input logic [1:0] mode,
      input logic [1:0] a
   );
      logic [3:0] be;
      be = 4'b0000;
      unique case (1'b1)
         (mode == LM_WORD):   be = 4'b1111;
         (mode == LM_HALF_S): be = a[1] ? 4'b1100 : 4'b0011;
         default:             be = 4'b0001 << a;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_data(
      input logic [1:0]  mode,
      input logic [31:0] rt
   );
      logic [31:0] d;
      d = rt;
      unique case (1'b1)
         (mode == LM_WORD):   d = rt;
         (mode == LM_HALF_S): d = {2{rt[15:0]}};
         default:             d = {4{rt[7:0]}};
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extract(
      input logic [1:0]  mode,
      input logic [1:0]  a,
      input logic [31:0] w
   );
      logic [15:0] h;
      logic [7:0]  b;
      logic [31:0] r;
      h = a[1] ? w[31:16] : w[15:0];
      b = w[{a, 3'b000} +: 8];
      r = w;
      unique case (1'b1)
         (mode == LM_WORD):   r = w;
         (mode == LM_HALF_S): r = {{16{h[15]}}, h};
         (mode == LM_BYTE_S): r = {{24{b[7]}}, b};
         default:             r = {24'h0, b};
      endcase
      return r;
   endfunction

   function automatic logic misaligned(
      input logic [1:0] mode,
      input logic [1:0] a
   );
      logic m;
      m = 1'b0;
      unique case (1'b1)
         (mode == LM_WORD):   m = (a != 2'b00);
         (mode == LM_HALF_S): m = a[0];
         default:             m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register.
// When not loading, the retire flags drop so nothing retires twice.
module MEM_WB_Reg
   import mips_mem_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    en,
   input  mem_wb_t d,
   output mem_wb_t q
);

   // load a new bundle, or squash the retire flags and hold the data
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end else begin
         q.valid      <= 1'b0;
         q.reg_write  <= 1'b0;
         q.mem_to_reg <= 1'b0;
         q.misalign   <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: variable-latency data-memory handshake,
// upstream stall, load extraction and MEM/WB register.
module mem_stage
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_RegWrite,
   input  logic        in_MemWrite,
   input  logic        in_MemRead,
   input  logic        in_MemToReg,
   input  logic [1:0]  in_load_mode,
   input  logic [4:0]  in_writebackDestination,
   input  logic [31:0] in_aluResult,
   input  logic [31:0] in_rt,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        valid_out,
   output logic        RegWrite_out,
   output logic        MemToReg_out,
   output logic [4:0]  writebackDestination_out,
   output logic [31:0] aluResult_out,
   output logic [31:0] readData_out,
   output logic        misalign_out,
   output logic        bus_error
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   mem_state_t  state_q, state_d;
   logic [CW-1:0] wait_cnt_q;

   logic        lat_we, lat_rw, lat_m2r, lat_to;
   logic [1:0]  lat_mode;
   logic [4:0]  lat_dest;
   logic [31:0] lat_alu, lat_wdata, lat_rdata;
   logic [3:0]  lat_be;
   logic        bus_error_q;

   logic        is_mem, mis_op, mem_op, timeout;
   logic        wb_en;
   mem_wb_t     wb_d, wb_q;

   assign is_mem  = in_valid & (in_MemRead | in_MemWrite);
   assign mis_op  = is_mem &
                    misaligned(in_load_mode, in_aluResult[1:0]);
   assign mem_op  = is_mem & ~mis_op;
   assign timeout = (wait_cnt_q == CNT_LAST);

   assign mem_we    = lat_we;
   assign mem_addr  = {lat_alu[31:2], 2'b00};
   assign mem_be    = lat_be;
   assign mem_wdata = lat_wdata;
   assign bus_error = bus_error_q;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // next state, handshake outputs and MEM/WB load bundle
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      mem_req = 1'b0;
      wb_en   = 1'b0;
      wb_d    = '0;
      case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               stall   = 1'b1;
               state_d = S_ACCESS;
            end else begin
               wb_en           = 1'b1;
               wb_d.valid      = in_valid;
               wb_d.reg_write  = in_valid & in_RegWrite & ~mis_op;
               wb_d.mem_to_reg = in_valid & in_MemToReg;
               wb_d.misalign   = mis_op;
               wb_d.dest       = in_writebackDestination;
               wb_d.alu        = in_aluResult;
            end
         end
         S_ACCESS: begin
            stall   = 1'b1;
            mem_req = 1'b1;
            if (mem_ready | timeout) state_d = S_DONE;
         end
         S_DONE: begin
            wb_en           = 1'b1;
            wb_d.valid      = 1'b1;
            wb_d.reg_write  = lat_rw & ~lat_to;
            wb_d.mem_to_reg = lat_m2r;
            wb_d.dest       = lat_dest;
            wb_d.alu        = lat_alu;
            wb_d.rdata      = (lat_we | lat_to) ? 32'h0 :
               load_extract(lat_mode, lat_alu[1:0], lat_rdata);
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // wait counter restarts every time ACCESS is entered
   always_ff @(posedge clk) begin
      if (rst)                    wait_cnt_q <= '0;
      else if (state_q == S_ACCESS) wait_cnt_q <= wait_cnt_q + 1'b1;
      else                        wait_cnt_q <= '0;
   end

   // capture the held instruction and the access result
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_we    <= 1'b0;
         lat_rw    <= 1'b0;
         lat_m2r   <= 1'b0;
         lat_to    <= 1'b0;
         lat_mode  <= LM_WORD;
         lat_dest  <= '0;
         lat_alu   <= '0;
         lat_be    <= '0;
         lat_wdata <= '0;
         lat_rdata <= '0;
      end else begin
         if (state_q == S_IDLE && mem_op) begin
            lat_we    <= in_MemWrite;
            lat_rw    <= in_RegWrite;
            lat_m2r   <= in_MemToReg;
            lat_to    <= 1'b0;
            lat_mode  <= in_load_mode;
            lat_dest  <= in_writebackDestination;
            lat_alu   <= in_aluResult;
            lat_be    <= byte_en(in_load_mode, in_aluResult[1:0]);
            lat_wdata <= store_data(in_load_mode, in_rt);
         end
         if (state_q == S_ACCESS) begin
            if (mem_ready)    lat_rdata <= mem_rdata;
            else if (timeout) lat_to    <= 1'b1;
         end
      end
   end

   // sticky bus error on an abandoned access
   always_ff @(posedge clk) begin
      if (rst) bus_error_q <= 1'b0;
      else if (state_q == S_ACCESS && !mem_ready && timeout)
         bus_error_q <= 1'b1;
   end

   MEM_WB_Reg u_mem_wb (
      .clk (clk),
      .rst (rst),
      .en  (wb_en),
      .d   (wb_d),
      .q   (wb_q)
   );

   assign valid_out                = wb_q.valid;
   assign RegWrite_out             = wb_q.reg_write;
   assign MemToReg_out             = wb_q.mem_to_reg;
   assign misalign_out             = wb_q.misalign;
   assign writebackDestination_out = wb_q.dest;
   assign aluResult_out            = wb_q.alu;
   assign readData_out             = wb_q.rdata;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/stores, misalign,
// timeout and reset-during-access.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_RegWrite, in_MemWrite;
   logic        in_MemRead, in_MemToReg;
   logic [1:0]  in_load_mode;
   logic [4:0]  in_writebackDestination;
   logic [31:0] in_aluResult, in_rt;
   logic        stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        valid_out, RegWrite_out, MemToReg_out;
   logic [4:0]  writebackDestination_out;
   logic [31:0] aluResult_out, readData_out;
   logic        misalign_out, bus_error;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .in_valid                 (in_valid),
      .in_RegWrite              (in_RegWrite),
      .in_MemWrite              (in_MemWrite),
      .in_MemRead               (in_MemRead),
      .in_MemToReg              (in_MemToReg),
      .in_load_mode             (in_load_mode),
      .in_writebackDestination  (in_writebackDestination),
      .in_aluResult             (in_aluResult),
      .in_rt                    (in_rt),
      .stall                    (stall),
      .mem_req                  (mem_req),
      .mem_we                   (mem_we),
      .mem_addr                 (mem_addr),
      .mem_be                   (mem_be),
      .mem_wdata                (mem_wdata),
      .mem_ready                (mem_ready),
      .mem_rdata                (mem_rdata),
      .valid_out                (valid_out),
      .RegWrite_out             (RegWrite_out),
      .MemToReg_out             (MemToReg_out),
      .writebackDestination_out (writebackDestination_out),
      .aluResult_out            (aluResult_out),
      .readData_out             (readData_out),
      .misalign_out             (misalign_out),
      .bus_error                (bus_error)
   );

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic        mis;
      logic [4:0]  dest;
      logic [31:0] alu;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_a, mon_e;
   int   n_vec = 0;
   int   n_bad = 0;

   int          ready_at = -1;
   int          req_n = 0;
   logic [31:0] mem_word = '0;

   logic        obs_we;
   logic [3:0]  obs_be;
   logic [31:0] obs_addr, obs_wdata;
   int          st, rq;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_wb(input logic rw, input logic m2r,
                            input logic mis, input logic [4:0] d,
                            input logic [31:0] a,
                            input logic [31:0] r);
      exp_q.push_back({rw, m2r, mis, d, a, r});
   endtask

   // memory responder: raise mem_ready on the chosen request cycle
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_req) begin
            req_n++;
            mem_ready = (req_n == ready_at);
         end else begin
            req_n     = 0;
            mem_ready = 1'b0;
         end
         mem_rdata = mem_word;
      end
   end

   // monitor: every retirement is popped and compared
   always @(negedge clk) begin
      if (!rst && valid_out) begin
         mon_a = {RegWrite_out, MemToReg_out, misalign_out,
                  writebackDestination_out, aluResult_out,
                  readData_out};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL wb_unexpected: got %h expected none",
                     mon_a);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_a !== mon_e) begin
               n_bad++;
               $display("FAIL wb_retire: got %h expected %h",
                        mon_a, mon_e);
            end
         end
      end
   end

   // present one instruction (called at posedge+1) until it leaves
   task automatic issue(input logic rd, input logic wr,
                        input logic rw, input logic m2r,
                        input logic [1:0] mode,
                        input logic [4:0] dst,
                        input logic [31:0] alu,
                        input logic [31:0] rt,
                        output int stalls, output int reqs);
      in_valid                = 1'b1;
      in_MemRead              = rd;
      in_MemWrite             = wr;
      in_RegWrite             = rw;
      in_MemToReg             = m2r;
      in_load_mode            = mode;
      in_writebackDestination = dst;
      in_aluResult            = alu;
      in_rt                   = rt;
      stalls = 0;
      reqs   = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mem_req) begin
            reqs++;
            obs_we    = mem_we;
            obs_be    = mem_be;
            obs_addr  = mem_addr;
            obs_wdata = mem_wdata;
         end
         if (!stall) break;
         stalls++;
         if (i == 99) begin
            n_vec++;
            n_bad++;
            $display("FAIL stall_bound: got stuck expected release");
         end
      end
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      in_MemRead  = 1'b0;
      in_MemWrite = 1'b0;
      in_RegWrite = 1'b0;
      in_MemToReg = 1'b0;
   endtask

   initial begin
      rst                     = 1'b1;
      in_valid                = 1'b0;
      in_RegWrite             = 1'b0;
      in_MemWrite             = 1'b0;
      in_MemRead              = 1'b0;
      in_MemToReg             = 1'b0;
      in_load_mode            = 2'b00;
      in_writebackDestination = '0;
      in_aluResult            = '0;
      in_rt                   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_req", mem_req, 0);
      check("rst_valid", valid_out, 0);
      check("rst_rw", RegWrite_out, 0);
      check("rst_berr", bus_error, 0);
      check("rst_alu", aluResult_out, 0);
      check("rst_rdata", readData_out, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_be", mem_be, 0);
      check("rst_wdata", mem_wdata, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // non-memory op
      expect_wb(1, 0, 0, 5'd5, 32'h1234, 0);
      issue(0, 0, 1, 0, 2'b00, 5'd5, 32'h1234, 0, st, rq);
      check("alu_stall", st, 0);
      check("alu_req", rq, 0);

      // LB signed at 0x103, ready on second request cycle
      ready_at = 2;
      mem_word = 32'h80FF_0000;
      expect_wb(1, 1, 0, 5'd7, 32'h103, 32'hFFFF_FF80);
      issue(1, 0, 1, 1, 2'b10, 5'd7, 32'h103, 0, st, rq);
      check("lb_stall", st, 3);
      check("lb_req", rq, 2);
      check("lb_be", obs_be, 4'b1000);
      check("lb_we", obs_we, 0);
      check("lb_addr", obs_addr, 32'h100);

      // SH at 0x22
      ready_at = 1;
      expect_wb(0, 0, 0, 5'd0, 32'h22, 0);
      issue(0, 1, 0, 0, 2'b01, 5'd0, 32'h22, 32'hABCD, st, rq);
      check("sh_we", obs_we, 1);
      check("sh_be", obs_be, 4'b1100);
      check("sh_wdata_hi", {16'h0, obs_wdata[31:16]}, 32'hABCD);
      check("sh_addr", obs_addr, 32'h20);
      check("sh_stall", st, 2);

      // misaligned LW at 0x06
      expect_wb(0, 1, 1, 5'd3, 32'h6, 0);
      issue(1, 0, 1, 1, 2'b00, 5'd3, 32'h6, 0, st, rq);
      check("mis_req", rq, 0);
      check("mis_stall", st, 0);

      // LH signed, upper half
      ready_at = 1;
      mem_word = 32'h8001_7FFF;
      expect_wb(1, 1, 0, 5'd8, 32'h102, 32'hFFFF_8001);
      issue(1, 0, 1, 1, 2'b01, 5'd8, 32'h102, 0, st, rq);
      check("lh_be", obs_be, 4'b1100);

      // LBU lane 1
      mem_word = 32'h0000_F000;
      expect_wb(1, 1, 0, 5'd9, 32'h101, 32'h0000_00F0);
      issue(1, 0, 1, 1, 2'b11, 5'd9, 32'h101, 0, st, rq);
      check("lbu_be", obs_be, 4'b0010);

      // LW minimum latency
      mem_word = 32'hDEAD_BEEF;
      expect_wb(1, 1, 0, 5'd4, 32'h200, 32'hDEAD_BEEF);
      issue(1, 0, 1, 1, 2'b00, 5'd4, 32'h200, 0, st, rq);
      check("lw_stall", st, 2);
      check("lw_be", obs_be, 4'b1111);

      // SB with both read and write set behaves as store
      ready_at = 3;
      expect_wb(0, 0, 0, 5'd0, 32'h3, 0);
      issue(1, 1, 0, 0, 2'b10, 5'd0, 32'h3, 32'h1234_5678, st, rq);
      check("sb_we", obs_we, 1);
      check("sb_be", obs_be, 4'b1000);
      check("sb_wdata", obs_wdata, 32'h7878_7878);
      check("sb_stall", st, 4);
      check("berr_clear", bus_error, 0);

      // timeout: no mem_ready
      ready_at = -1;
      expect_wb(0, 1, 0, 5'd10, 32'h40, 0);
      issue(1, 0, 1, 1, 2'b00, 5'd10, 32'h40, 0, st, rq);
      check("to_req", rq, 4);
      check("to_stall", st, 5);
      @(negedge clk);
      check("to_berr", bus_error, 1);
      check("to_req_low", mem_req, 0);
      @(posedge clk);
      #1;

      // normal access after timeout; bus_error stays set
      ready_at = 1;
      mem_word = 32'hCAFE_F00D;
      expect_wb(1, 1, 0, 5'd11, 32'h44, 32'hCAFE_F00D);
      issue(1, 0, 1, 1, 2'b00, 5'd11, 32'h44, 0, st, rq);
      check("berr_sticky", bus_error, 1);

      // reset in the second ACCESS cycle
      ready_at                = -1;
      in_valid                = 1'b1;
      in_MemRead              = 1'b1;
      in_RegWrite             = 1'b1;
      in_load_mode            = 2'b00;
      in_writebackDestination = 5'd12;
      in_aluResult            = 32'h48;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_MemRead  = 1'b0;
      in_RegWrite = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rsta_req", mem_req, 0);
      check("rsta_stall", stall, 0);
      check("rsta_valid", valid_out, 0);
      check("rsta_berr", bus_error, 0);
      check("rsta_alu", aluResult_out, 0);
      check("rsta_addr", mem_addr, 0);
      @(posedge clk);
      #1;

      ready_at = 1;
      mem_word = 32'h1122_3344;
      expect_wb(1, 1, 0, 5'd13, 32'h80, 32'h1122_3344);
      issue(1, 0, 1, 1, 2'b00, 5'd13, 32'h80, 0, st, rq);
      check("post_rst_stall", st, 2);

      repeat (3) @(negedge clk);
      check("sb_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It consumes the EX/MEM pipeline-register fields and performs loads and stores through a variable-latency data-memory handshake. It stalls the upstream pipeline while an access is outstanding, then extracts and sign-extends load data. Its MEM/WB pipeline register feeds write-back.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles in ACCESS waiting for mem_ready before the access is aborted.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX/MEM slot holds a real instruction.
- in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg  in  1 each  EX/MEM control fields.
- in_load_mode  in  2  access width/sign: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned. For stores, signedness is ignored.
- in_writebackDestination  in  5  destination register.
- in_aluResult  in  32  effective address or ALU result.
- in_rt  in  32  store data.
- stall  out  1  upstream must hold all in_* fields.
- mem_req  out  1  access request.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word-aligned address, {in_aluResult[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  store data, replicated to the selected lanes.
- mem_ready  in  1  access complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.
- valid_out, RegWrite_out, MemToReg_out  out  1 each  MEM/WB fields.
- writebackDestination_out  out  5  MEM/WB destination register.
- aluResult_out, readData_out  out  32 each  MEM/WB data.
- misalign_out  out  1  the retired instruction was a misaligned memory op.
- bus_error  out  1  sticky timeout flag, cleared only by rst.

## Operation
- Little-endian byte lanes: byte k is bits [8k+7:8k].
- Half accesses use lane pair addr[1]. Byte accesses use lane addr[1:0].
- Misalignment rules:
  - Word access: misaligned if addr[1:0]≠0.
  - Half access: misaligned if addr[0]=1.
  - A misaligned op issues no memory request. It retires next cycle with RegWrite_out=0 and misalign_out=1.
- A memory op is in_valid & (in_MemRead | in_MemWrite) & aligned. If both in_MemRead and in_MemWrite are set, the op is a store.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, non-memory op or bubble: stall=0. The MEM/WB register loads the inputs at the next edge with readData_out=0.
  - IDLE, memory op: stall=1. Address, be, wdata, we and mode are latched. Next state is ACCESS. valid_out=0 at the next edge.
  - ACCESS: mem_req=1 and stall=1, with the latched mem_* values held stable.
    - On mem_ready: mem_rdata is latched and the next state is DONE.
    - On the wait counter reaching TIMEOUT_CYCLES: bus_error is set and the next state is DONE.
  - DONE: mem_req=0, stall=0. The held instruction retires into MEM/WB at this edge.
    - readData_out is the extracted load data: zero- or sign-extended per mode, and 0 for stores.
    - RegWrite_out is forced 0 if the access timed out.
    - Next state is IDLE.
- Outputs carry valid_out=0 and RegWrite_out=0 on every edge that does not retire an instruction.

## Timing
- Non-memory op presented in cycle N appears on the outputs at N+1.
- Memory op presented at N:
  - mem_req is high from N+1.
  - If mem_ready arrives at cycle M≥N+1, DONE occurs at M+1 and the outputs update at M+2.
  - Minimum latency is 3 cycles.
- stall is combinational: high in IDLE when a memory op is present, and high throughout ACCESS.
- Back-to-back memory ops: after DONE the block returns to IDLE, so a new access starts one cycle later. There is no overlap.
- Timeout: the counter clears on entry to ACCESS. On a timeout, mem_req drops in DONE and a later mem_ready is ignored.
- rst during ACCESS: mem_req=0 and the state is IDLE at the next edge. No retirement occurs.
- Reset values: all outputs 0 (stall, mem_req, valid_out, RegWrite_out, bus_error, all data buses); counter 0; state IDLE.

## Structure
- Package mips_mem_pkg holds:
  - load_mode encodings (LM_WORD, LM_HALF_S, LM_BYTE_S, LM_BYTE_U);
  - the FSM state enum;
  - the byte-enable and load-extract functions.
- Sub-module MEM_WB_Reg holds the registered MEM/WB fields, with synchronous reset and a load enable.
- The FSM, alignment check and timeout counter live in mem_stage.

## Test plan
- Non-memory op, aluResult=0x1234, RegWrite=1, dest=5 → one cycle later valid_out=1, aluResult_out=0x1234, readData_out=0, stall never high.
- LB signed at addr 0x103, mem_rdata=0x80FF_0000 with mem_ready 2 cycles after mem_req → mem_be=4'b1000, readData_out=0xFFFF_FF80, stall high for exactly 3 cycles.
- SH at addr 0x22, rt=0xABCD → mem_we=1, mem_be=4'b1100, mem_wdata[31:16]=0xABCD, mem_addr=0x20; retires with readData_out=0.
- LW at addr 0x06 → no mem_req; next cycle misalign_out=1, RegWrite_out=0.
- LW with mem_ready never asserted, TIMEOUT_CYCLES=4 → mem_req high for 4 cycles then low, bus_error=1 and stays 1, RegWrite_out=0 at retirement.
- rst asserted in the second ACCESS cycle → next edge: mem_req=0, stall=0, all outputs 0; a following LW completes normally.
